// File: rtl/div_if.sv
// Request/response bundle for the iterative divider: operands in, quotient/remainder/flags out.
interface div_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            signed_mode;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            divide_by_zero;
  logic            overflow;

  modport master (
    output in_valid, signed_mode, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, divide_by_zero, overflow
  );

  modport slave (
    input  in_valid, signed_mode, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, divide_by_zero, overflow
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider, signed/unsigned, 1 or 2 quotient bits per cycle.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | restoring iterations in progress, count_q steps left
//   DONE  | result registered, waiting for out_ready
module div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  div_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   STEPS    = CW'(XLEN / BITS_PER_CYCLE);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [XLEN-1:0] quo_out_q, quo_out_d;
  logic [XLEN-1:0] rem_out_q, rem_out_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            div_zero;
  logic            load_calc;
  logic            load_zero;
  logic            iterate;
  logic            finish;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_dvd;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic            is_signed);
    magnitude = (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

  assign bus.in_ready       = (state_q == S_IDLE) && !flush;
  assign bus.out_valid      = (state_q == S_DONE);
  assign bus.quotient       = quo_out_q;
  assign bus.remainder      = rem_out_q;
  assign bus.divide_by_zero = dbz_q;
  assign bus.overflow       = ovf_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign div_zero = (bus.divisor == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_calc = 1'b0;
    load_zero = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (div_zero) begin
              state_d   = S_DONE;
              load_zero = 1'b1;
            end else begin
              state_d   = S_CALC;
              load_calc = 1'b1;
            end
          end
        end
        S_CALC: begin
          iterate = 1'b1;
          if (count_q == CW'(1)) begin
            state_d = S_DONE;
            finish  = 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Chained restoring steps; quotient bits shift into dvd from the LSB as dividend bits leave the MSB.
  always_comb begin
    step_rem = rem_q;
    step_dvd = dvd_q;
    trial    = '0;
    diff     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial    = {step_rem, step_dvd[XLEN-1]};
      diff     = trial - {1'b0, dsr_q};
      step_dvd = {step_dvd[XLEN-2:0], ~diff[XLEN]};
      step_rem = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

  always_comb begin
    count_d    = count_q;
    dsr_d      = dsr_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    quo_out_d  = quo_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    if (load_calc) begin
      count_d    = STEPS;
      dsr_d      = magnitude(bus.divisor, bus.signed_mode);
      dvd_d      = magnitude(bus.dividend, bus.signed_mode);
      rem_d      = '0;
      neg_quo_d  = bus.signed_mode & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
      neg_rem_d  = bus.signed_mode & bus.dividend[XLEN-1];
      ovf_pend_d = bus.signed_mode && (bus.dividend == MOST_NEG) && (&bus.divisor);
    end
    if (load_zero) begin
      quo_out_d = '0;
      rem_out_d = bus.dividend;
      dbz_d     = 1'b1;
      ovf_d     = 1'b0;
    end
    if (iterate) begin
      count_d = count_q - CW'(1);
      dvd_d   = step_dvd;
      rem_d   = step_rem;
    end
    // Most-negative / -1 needs no special case: negation of 2^(XLEN-1) wraps to itself.
    if (finish) begin
      quo_out_d = neg_quo_q ? -step_dvd : step_dvd;
      rem_out_d = neg_rem_q ? -step_rem : step_rem;
      dbz_d     = 1'b0;
      ovf_d     = ovf_pend_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      dsr_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_out_q  <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      dsr_q      <= dsr_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      quo_out_q  <= quo_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: one instance per BITS_PER_CYCLE setting, shared stimulus steered by sel.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_signed = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_if #(.XLEN(32)) b1 ();
  div_if #(.XLEN(32)) b2 ();

  assign b1.in_valid    = req_valid & ~sel;
  assign b1.signed_mode = req_signed;
  assign b1.dividend    = req_a;
  assign b1.divisor     = req_b;
  assign b1.out_ready   = rdy & ~sel;
  assign b2.in_valid    = req_valid & sel;
  assign b2.signed_mode = req_signed;
  assign b2.dividend    = req_a;
  assign b2.divisor     = req_b;
  assign b2.out_ready   = rdy & sel;

  logic        o_in_ready, o_out_valid, o_dbz, o_ovf;
  logic [31:0] o_quo, o_rem;
  assign o_in_ready  = sel ? b2.in_ready       : b1.in_ready;
  assign o_out_valid = sel ? b2.out_valid      : b1.out_valid;
  assign o_dbz       = sel ? b2.divide_by_zero : b1.divide_by_zero;
  assign o_ovf       = sel ? b2.overflow       : b1.overflow;
  assign o_quo       = sel ? b2.quotient       : b1.quotient;
  assign o_rem       = sel ? b2.remainder      : b1.remainder;

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(b1)
  );

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic sm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_signed = sm;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    #1;
    check("in_ready_before_accept", {31'b0, o_in_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // lat = rising edges after the accept edge until out_valid is seen (0 = valid right after accept).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!o_out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk) rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic sm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input logic eovf, input int elat);
    int lat;
    start_req(sm, a, b);
    wait_out(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_quo"}, o_quo, eq);
    check({tag, "_rem"}, o_rem, er);
    check({tag, "_dbz"}, {31'b0, o_dbz}, {31'b0, edbz});
    check({tag, "_ovf"}, {31'b0, o_ovf}, {31'b0, eovf});
    take();
  endtask

  task automatic watch_silent(input string tag);
    int seen;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    #1 resetn = 1'b0;
    #10;
    check("rst_in_ready", {31'b0, o_in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("rst_quo", o_quo, 32'd0);
    check("rst_rem", o_rem, 32'd0);
    check("rst_flags", {30'b0, o_dbz, o_ovf}, 32'd0);
    @(negedge clk) resetn = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 32);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 32);
    run_op("dbz", 1'b0, 32'h0000_1234, 32'd0, 32'd0, 32'h0000_1234, 1'b1, 1'b0, 0);

    // Stall in DONE with a competing request, then back-to-back accept.
    start_req(1'b0, 32'd100, 32'd7);
    wait_out(lat);
    check("stall_lat", 32'(lat), 32'd32);
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = 32'd55;
    req_b     = 32'd5;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", {31'b0, o_out_valid}, 32'd1);
      check("stall_in_ready", {31'b0, o_in_ready}, 32'd0);
      check("stall_quo", o_quo, 32'd14);
      check("stall_rem", o_rem, 32'd2);
    end
    @(negedge clk);
    rdy   = 1'b1;
    req_a = 32'd50;
    req_b = 32'd5;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    check("release_in_ready", {31'b0, o_in_ready}, 32'd1);
    check("release_out_valid", {31'b0, o_out_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("b2b_accepted", {31'b0, o_in_ready}, 32'd0);
    wait_out(lat);
    check("b2b_lat", 32'(lat), 32'd32);
    check("b2b_quo", o_quo, 32'd10);
    check("b2b_rem", o_rem, 32'd0);
    take();

    // Flush ten cycles into CALC, held for two edges with a competing request.
    start_req(1'b0, 32'd12345, 32'd11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'd77;
    req_b     = 32'd7;
    @(posedge clk);
    #1;
    check("flush_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, o_in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_flush_in_ready", {31'b0, o_in_ready}, 32'd1);
    watch_silent("flush_no_result");
    run_op("flush_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 32);

    // Reset pulse mid-CALC.
    start_req(1'b0, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk) resetn = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, o_out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, o_in_ready}, 32'd1);
    check("midrst_quo", o_quo, 32'd0);
    @(negedge clk) resetn = 1'b1;
    watch_silent("reset_no_result");
    run_op("rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 32);

    // Two bits per cycle instance.
    @(negedge clk) sel = 1'b1;
    run_op("b2_s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 16);
    run_op("b2_u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 16);
    run_op("b2_s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
